// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request per handshake, fixed LATENCY, response held until consumed.
// Optional store trace compiled in with `define DMEM_TRACE_EN.
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [31:2]         r_addr;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [31:0]         r_pc;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_access;
  logic                w_oob;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_rd_word;
  logic [31:0]         w_merged;
  logic                w_unused;

  // Byte-offset bits and the trace-only PC carry no function in a plain build.
  assign w_unused = ^{req_addr[1:0], r_pc};

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_access  = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_oob     = |r_addr[31:ADDR_W+2];
  assign w_idx     = r_addr[ADDR_W+1:2];
  assign w_rd_word = r_mem[w_idx];

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : w_rd_word[8*i +: 8];
    end
  end

  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (req_valid)       w_next_state = S_BUSY;
      S_BUSY: if (r_cnt == 4'd0)   w_next_state = S_RESP;
      S_RESP: if (rsp_ready)       w_next_state = S_IDLE;
      default:                     w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_pc        <= 32'd0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr[31:2];
        r_be    <= req_be;
        r_wdata <= req_wdata;
        r_pc    <= req_pc;
        r_cnt   <= 4'(LATENCY - 1);
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        if (w_oob) begin
          r_rsp_rdata <= 32'd0;
          r_rsp_err   <= 1'b1;
        end else begin
          r_rsp_rdata <= r_we ? w_merged : w_rd_word;
          r_rsp_err   <= 1'b0;
        end
      end
    end
  end

  // NOTE: the memory array is reset here because a reset must leave every word reading as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_access && r_we && !w_oob) begin
      r_mem[w_idx] <= w_merged;
`ifdef DMEM_TRACE_EN
      if (|r_be) begin
        $display("%d@%h: *%h <= %h", $time, r_pc, {r_addr, 2'b00}, w_merged);
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues expected responses at accept time,
// a monitor pops and compares them as responses appear and enforces latency and hold stability.
module tb_dmem_responder;

  localparam int ADDR_W = 12;
  localparam int LAT    = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hold;
    int          accept_edge;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, wait for acceptance (bounded), and queue its expected response.
  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    req_pc    = 32'h0000_3000;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check({name, "_accept"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      e.rdata       = exp_rdata;
      e.err         = exp_err;
      e.hold        = hold;
      e.accept_edge = cyc + 1;
      e.name        = name;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  // Monitor: compare on the rising of rsp_valid, then watch the held response until consumed.
  exp_t        cur;
  logic        in_rsp     = 1'b0;
  logic        handshook  = 1'b0;
  int          held       = 0;
  logic [31:0] held_rdata = 32'd0;
  logic        held_err   = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      in_rsp    = 1'b0;
      handshook = 1'b0;
      held      = 0;
      rsp_ready = 1'b0;
    end else begin
      if (handshook) begin
        check({cur.name, "_drop_valid"}, 32'(rsp_valid), 32'd0);
        check({cur.name, "_back_idle"}, 32'(req_ready), 32'd1);
        handshook = 1'b0;
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(sb.size()), 32'd1);
            cur.name = "unexpected";
            held     = 0;
          end else begin
            cur = sb.pop_front();
            check({cur.name, "_latency"}, 32'(cyc), 32'(cur.accept_edge + LAT));
            check({cur.name, "_rdata"}, rsp_rdata, cur.rdata);
            check({cur.name, "_err"}, 32'(rsp_err), 32'(cur.err));
            held = cur.hold;
          end
          held_rdata = rsp_rdata;
          held_err   = rsp_err;
        end else begin
          check({cur.name, "_hold_rdata"}, rsp_rdata, held_rdata);
          check({cur.name, "_hold_err"}, 32'(rsp_err), 32'(held_err));
          check({cur.name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        if (held > 0) begin
          rsp_ready = 1'b0;
          held--;
        end else begin
          rsp_ready = 1'b1;
          handshook = 1'b1;
        end
      end else begin
        in_rsp    = 1'b0;
        rsp_ready = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_be    = 4'd0;
    req_wdata = 32'd0;
    req_pc    = 32'd0;
    rsp_ready = 1'b0;
    #12;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full-word store then load back.
    issue("st_full", 1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    issue("ld_full", 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h1234_5678, 1'b0, 0);
    // Single-lane store merges into the existing word.
    issue("st_lane1", 1'b1, 32'h0000_0010, 4'b0010, 32'h0000_AB00, 32'h1234_AB78, 1'b0, 0);
    issue("ld_lane1", 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h1234_AB78, 1'b0, 0);
    // Response held for three cycles of back-pressure.
    issue("ld_stall", 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h1234_AB78, 1'b0, 3);
    // Out-of-range store must not alias onto word 0.
    issue("st_w0",   1'b1, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 0);
    issue("st_oob",  1'b1, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 0);
    issue("ld_w0",   1'b0, 32'h0000_0000, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b0, 0);
    issue("ld_oob",  1'b0, 32'h8000_0010, 4'b0000, 32'h0,         32'h0000_0000, 1'b1, 1);
    // Empty byte-enable store returns the unchanged word.
    issue("st_be0",  1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h1234_AB78, 1'b0, 0);
    issue("ld_be0",  1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h1234_AB78, 1'b0, 0);
    // Top word of the array, sparse lanes, unaligned byte offset on the load.
    issue("st_top",  1'b1, 32'h0000_3FFC, 4'b1001, 32'hA5FF_FF5A, 32'hA500_005A, 1'b0, 2);
    issue("ld_top",  1'b0, 32'h0000_3FFE, 4'b0000, 32'h0,         32'hA500_005A, 1'b0, 0);

    // Reset while a store is in flight: dropped, memory cleared.
    issue("st_drop", 1'b1, 32'h0000_0010, 4'b1111, 32'h1111_1111, 32'h1111_1111, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    check("busy_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("busy_reset_req_ready", 32'(req_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    issue("ld_after_rst", 1'b0, 32'h0000_0010, 4'b0000, 32'h0, 32'h0000_0000, 1'b0, 0);
    issue("ld_w0_rst",    1'b0, 32'h0000_0000, 4'b0000, 32'h0, 32'h0000_0000, 1'b0, 0);

    drain = 0;
    while ((sb.size() != 0 || rsp_valid) && drain < 50) begin
      @(negedge clk);
      drain++;
    end
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_idle", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
